// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
package hazard_forward_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 16;

   // Forward-source select encoding
   localparam logic FWD_MEM = 1'b0;
   localparam logic FWD_WB  = 1'b1;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             wb_en;
      logic             mem_read;
   } trk_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Compares one ID source register against one tracked pipeline entry.
module hazard_src_match
   import hazard_forward_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             src_used,
   input  trk_entry_t       entry,
   output logic             match_c
);

   // r0 is hard-wired zero, so a write to it never creates a dependency
   assign match_c = src_used & entry.valid & entry.wb_en &
                    (entry.dest != '0) & (entry.dest == src);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use / RAW stall, branch flush and operand-forward select for a 5-stage pipe.
module hazard_forward_ctrl
   import hazard_forward_ctrl_pkg::*;
#(
   parameter logic FWD_DEFAULT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_src2_used,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_read,
   input  logic             branch_taken,
   input  logic             fwd_cfg_we,
   input  logic             fwd_cfg_en,
   output logic             stall,
   output logic             flush,
   output logic             should_forward1,
   output logic             should_forward2,
   output logic             fwd_sel1,
   output logic             fwd_sel2,
   output logic [CNT_W-1:0] stall_count
);

   trk_entry_t       exe_q, exe_d;
   trk_entry_t       mem_q, mem_d;
   logic             fwd_en_q, fwd_en_d;
   logic             sf1_q, sf1_d, sf2_q, sf2_d;
   logic             sel1_q, sel1_d, sel2_q, sel2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic m1_exe, m2_exe, m1_mem, m2_mem;
   logic load_use, raw_any, fwd_ok;

   hazard_src_match u_m1_exe (.src(id_src1), .src_used(1'b1),         .entry(exe_q), .match_c(m1_exe));
   hazard_src_match u_m2_exe (.src(id_src2), .src_used(id_src2_used), .entry(exe_q), .match_c(m2_exe));
   hazard_src_match u_m1_mem (.src(id_src1), .src_used(1'b1),         .entry(mem_q), .match_c(m1_mem));
   hazard_src_match u_m2_mem (.src(id_src2), .src_used(id_src2_used), .entry(mem_q), .match_c(m2_mem));

   // Hazard decision, pipe shift and next forward selection
   always_comb begin
      flush    = branch_taken;
      load_use = exe_q.mem_read & (m1_exe | m2_exe);
      raw_any  = m1_exe | m2_exe | m1_mem | m2_mem;
      stall    = id_valid & ~branch_taken & (fwd_en_q ? load_use : raw_any);

      exe_d = '0;
      if (!(stall || flush)) begin
         exe_d.valid    = id_valid;
         exe_d.dest     = id_dest;
         exe_d.wb_en    = id_wb_en;
         exe_d.mem_read = id_mem_read;
      end
      mem_d = exe_q;

      // The EXE entry moves to MEM next cycle, so it is the newest producer
      fwd_ok = fwd_en_q & ~stall & ~flush;
      sf1_d  = fwd_ok & (m1_exe | m1_mem);
      sf2_d  = fwd_ok & (m2_exe | m2_mem);
      sel1_d = (fwd_ok && !m1_exe && m1_mem) ? FWD_WB : FWD_MEM;
      sel2_d = (fwd_ok && !m2_exe && m2_mem) ? FWD_WB : FWD_MEM;

      fwd_en_d = fwd_cfg_we ? fwd_cfg_en : fwd_en_q;

      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exe_q    <= '0;
         mem_q    <= '0;
         fwd_en_q <= FWD_DEFAULT;
         sf1_q    <= 1'b0;
         sf2_q    <= 1'b0;
         sel1_q   <= 1'b0;
         sel2_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         exe_q    <= exe_d;
         mem_q    <= mem_d;
         fwd_en_q <= fwd_en_d;
         sf1_q    <= sf1_d;
         sf2_q    <= sf2_d;
         sel1_q   <= sel1_d;
         sel2_q   <= sel2_d;
         cnt_q    <= cnt_d;
      end
   end

   assign should_forward1 = sf1_q;
   assign should_forward2 = sf2_q;
   assign fwd_sel1        = sel1_q;
   assign fwd_sel2        = sel2_q;
   assign stall_count     = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scenario bench for hazard_forward_ctrl.
module tb_hazard_forward_ctrl;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_src1, id_src2, id_dest;
   logic        id_src2_used, id_wb_en, id_mem_read;
   logic        branch_taken, fwd_cfg_we, fwd_cfg_en;
   logic        stall, flush;
   logic        should_forward1, should_forward2, fwd_sel1, fwd_sel2;
   logic [15:0] stall_count;

   int total = 0;
   int bad   = 0;

   hazard_forward_ctrl #(.FWD_DEFAULT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_src2_used(id_src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_read(id_mem_read), .branch_taken(branch_taken),
      .fwd_cfg_we(fwd_cfg_we), .fwd_cfg_en(fwd_cfg_en),
      .stall(stall), .flush(flush),
      .should_forward1(should_forward1), .should_forward2(should_forward2),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Present one ID instruction at the falling edge, let comb logic settle
   task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u2, input logic [4:0] d, input logic wb, input logic mr);
      @(negedge clk);
      id_valid = v; id_src1 = s1; id_src2 = s2; id_src2_used = u2;
      id_dest = d; id_wb_en = wb; id_mem_read = mr;
      branch_taken = 1'b0; fwd_cfg_we = 1'b0; fwd_cfg_en = 1'b0;
      #1;
   endtask

   task automatic nop();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_src2_used = 1'b0;
      id_dest = '0; id_wb_en = 1'b0; id_mem_read = 1'b0;
      branch_taken = 1'b0; fwd_cfg_we = 1'b0; fwd_cfg_en = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; branch_taken = 1'b1; id_valid = 1'b1;
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL rst_flush got=%b exp=1", flush); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
      total++; if ({should_forward1, should_forward2, fwd_sel1, fwd_sel2} !== 4'b0)
         begin bad++; $display("FAIL rst_fwd got=%b exp=0000", {should_forward1, should_forward2, fwd_sel1, fwd_sel2}); end
      total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", stall_count); end
      branch_taken = 1'b0; id_valid = 1'b0;
      #1 rst_n = 1'b1;
      nop();
      total++; if (stall !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL post_rst got=%b%b exp=00", stall, flush); end
   endtask

   task automatic test_fwd_exe();
      do_reset();
      drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);      // add r3,r1,r2
      drive(1, 5'd3, 5'd5, 1, 5'd4, 1, 0);      // sub r4,r3,r5
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL exe_stall got=%b exp=0", stall); end
      nop();
      total++; if ({should_forward1, fwd_sel1, should_forward2} !== 3'b100)
         begin bad++; $display("FAIL exe_fwd got=%b exp=100", {should_forward1, fwd_sel1, should_forward2}); end
   endtask

   task automatic test_fwd_mem();
      do_reset();
      drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);      // add r3
      nop();
      drive(1, 5'd2, 5'd3, 1, 5'd6, 1, 0);      // or r6,r2,r3
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL mem_stall got=%b exp=0", stall); end
      nop();
      total++; if ({should_forward2, fwd_sel2, should_forward1} !== 3'b110)
         begin bad++; $display("FAIL mem_fwd got=%b exp=110", {should_forward2, fwd_sel2, should_forward1}); end
      drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);      // add r3
      drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);      // add r3
      drive(1, 5'd3, 5'd0, 0, 5'd9, 1, 0);      // use r3
      nop();
      total++; if ({should_forward1, fwd_sel1} !== 2'b10)
         begin bad++; $display("FAIL newest_wins got=%b exp=10", {should_forward1, fwd_sel1}); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 5'd1, 5'd0, 0, 5'd7, 1, 1);      // lw r7
      drive(1, 5'd7, 5'd1, 1, 5'd8, 1, 0);      // add r8,r7,r1
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
      drive(1, 5'd7, 5'd1, 1, 5'd8, 1, 0);      // held in ID
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_len got=%b exp=0", stall); end
      total++; if (should_forward1 !== 1'b0) begin bad++; $display("FAIL lu_bubble_fwd got=%b exp=0", should_forward1); end
      nop();
      total++; if ({should_forward1, fwd_sel1} !== 2'b11)
         begin bad++; $display("FAIL lu_fwd got=%b exp=11", {should_forward1, fwd_sel1}); end
      total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_count); end
   endtask

   task automatic test_no_fwd();
      do_reset();
      nop(); fwd_cfg_we = 1'b1; fwd_cfg_en = 1'b0;
      drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);      // add r3
      drive(1, 5'd3, 5'd0, 0, 5'd4, 1, 0);      // use r3
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL nf_stall1 got=%b exp=1", stall); end
      drive(1, 5'd3, 5'd0, 0, 5'd4, 1, 0);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL nf_stall2 got=%b exp=1", stall); end
      drive(1, 5'd3, 5'd0, 0, 5'd4, 1, 0);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL nf_stall3 got=%b exp=0", stall); end
      nop();
      total++; if (should_forward1 !== 1'b0) begin bad++; $display("FAIL nf_fwd got=%b exp=0", should_forward1); end
      total++; if (stall_count !== 16'd2) begin bad++; $display("FAIL nf_cnt got=%0d exp=2", stall_count); end
   endtask

   task automatic test_cfg_switch();
      do_reset();
      drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);      // add r3
      drive(1, 5'd3, 5'd0, 0, 5'd4, 1, 0);      // use r3, disable in same cycle
      fwd_cfg_we = 1'b1; fwd_cfg_en = 1'b0; #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL cfg_old_stall got=%b exp=0", stall); end
      drive(1, 5'd1, 5'd2, 1, 5'd5, 1, 0);      // add r5
      total++; if ({should_forward1, fwd_sel1} !== 2'b10)
         begin bad++; $display("FAIL cfg_old_fwd got=%b exp=10", {should_forward1, fwd_sel1}); end
      drive(1, 5'd5, 5'd0, 0, 5'd6, 1, 0);      // use r5
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL cfg_new_stall got=%b exp=1", stall); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1, 5'd1, 5'd0, 0, 5'd7, 1, 1);      // lw r7
      drive(1, 5'd7, 5'd1, 1, 5'd8, 1, 0);      // add r8,r7 with taken branch
      branch_taken = 1'b1; #1;
      total++; if ({flush, stall} !== 2'b10) begin bad++; $display("FAIL fl_hazard got=%b exp=10", {flush, stall}); end
      nop();
      total++; if (should_forward1 !== 1'b0) begin bad++; $display("FAIL fl_fwd got=%b exp=0", should_forward1); end
      total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL fl_cnt got=%0d exp=0", stall_count); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL fl_clear got=%b exp=0", flush); end
      drive(1, 5'd1, 5'd2, 1, 5'd0, 1, 1);      // lw r0
      drive(1, 5'd0, 5'd0, 1, 5'd5, 1, 0);      // use r0
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall); end
      nop();
      total++; if ({should_forward1, should_forward2} !== 2'b00)
         begin bad++; $display("FAIL r0_fwd got=%b exp=00", {should_forward1, should_forward2}); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1, 5'd1, 5'd0, 0, 5'd7, 1, 1);      // lw r7
      drive(1, 5'd7, 5'd0, 0, 5'd8, 1, 0);      // use r7 -> stall
      drive(1, 5'd7, 5'd0, 0, 5'd8, 1, 0);
      drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);      // add r3
      drive(1, 5'd3, 5'd0, 0, 5'd7, 1, 1);      // lw r7,(r3)
      drive(1, 5'd7, 5'd0, 0, 5'd10, 1, 0);     // use r7 -> stall
      total++; if ({stall, should_forward1, stall_count} !== {1'b1, 1'b1, 16'd1})
         begin bad++; $display("FAIL ms_pre got=%b_%b_%0d exp=1_1_1", stall, should_forward1, stall_count); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({stall, flush, should_forward1, should_forward2, fwd_sel1, fwd_sel2, stall_count} !== 22'd0)
         begin bad++; $display("FAIL ms_async got=%b%b%b%b%b%b_%0h exp=0", stall, flush, should_forward1,
                               should_forward2, fwd_sel1, fwd_sel2, stall_count); end
      drive(1, 5'd1, 5'd2, 1, 5'd11, 1, 0);     // add r11, reset still low
      rst_n = 1'b1; #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL ms_release got=%b exp=0", stall); end
      drive(1, 5'd11, 5'd0, 0, 5'd12, 1, 0);    // use r11
      nop();
      total++; if ({should_forward1, fwd_sel1} !== 2'b10)
         begin bad++; $display("FAIL ms_no_bubble got=%b exp=10", {should_forward1, fwd_sel1}); end
   endtask

   task automatic test_saturation();
      do_reset();
      nop(); fwd_cfg_we = 1'b1; fwd_cfg_en = 1'b0;
      @(negedge clk);
      force dut.cnt_q = 16'hFFFD;
      #1 release dut.cnt_q;
      for (int k = 0; k < 2; k++) begin
         drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);   // add r3
         drive(1, 5'd3, 5'd0, 0, 5'd4, 1, 0);
         drive(1, 5'd3, 5'd0, 0, 5'd4, 1, 0);
         if (k == 0) begin
            total++; if (stall_count !== 16'hFFFE) begin bad++; $display("FAIL sat_mid got=%0h exp=fffe", stall_count); end
         end
         drive(1, 5'd3, 5'd0, 0, 5'd4, 1, 0);
         nop();
         total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold%0d got=%0h exp=ffff", k, stall_count); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_src2_used = 1'b0;
      id_dest = '0; id_wb_en = 1'b0; id_mem_read = 1'b0;
      branch_taken = 1'b0; fwd_cfg_we = 1'b0; fwd_cfg_en = 1'b0;
      test_reset();
      test_fwd_exe();
      test_fwd_mem();
      test_load_use();
      test_no_fwd();
      test_cfg_switch();
      test_flush();
      test_reset_mid_stall();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
